input_wr_dispatch: RTL
======================

INPUT_WR_DISPATCH -- requirements
Module: input_wr_dispatch

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 36: width of host data and FIFO write data.
REQ-002 SHALL have parameter DATA_IN_ADDR, default 16: number of FIFO rows, which is also the WR_EN width.
REQ-003 SHALL have parameter REG_ADDR, default 8: config address width.
REQ-004 SHALL have parameter REG_DATA_WIDTH, default 32: config data width.
REQ-005 SHALL have port CLK  input  1: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1: host word valid.
REQ-008 SHALL have port in_data  input  DATA_IN_WIDTH: host word.
REQ-009 SHALL have port in_ready  output  1: dispatcher accepts a word this cycle.
REQ-010 SHALL have port reg_en  input  1: config write strobe.
REQ-011 SHALL have port a_reg  input  REG_ADDR: config address.
REQ-012 SHALL have port d_reg  input  REG_DATA_WIDTH: config data.
REQ-013 SHALL have port col_en  input  1: column mode; only even rows are used.
REQ-014 SHALL have port fifo_full  input  1: aggregate full flag from the input FIFO.
REQ-015 SHALL have port WR_EN  output  DATA_IN_ADDR: one-hot row write enable to the input FIFO.
REQ-016 SHALL have port din  output  DATA_IN_WIDTH: write data to the input FIFO.
REQ-017 SHALL have port frame_done  output  1: single-cycle pulse marking the last write of a frame.
REQ-018 SHALL have port busy  output  1: asserted when state is RUN.

Function
REQ-019 Row mask register SHALL be written when reg_en=1 and a_reg=0x01, taking d_reg[15:0]; a write of 0x0000 SHALL be ignored.
REQ-020 Burst length register SHALL be written when reg_en=1 and a_reg=0x02, taking d_reg[3:0] as a value in 1..15; a write of 0 SHALL be ignored.
REQ-021 Config writes SHALL land in pending registers; the active mask, burst length and col_en SHALL be copied from pending/input only in state IDLE.
REQ-022 Effective mask SHALL be active_mask AND 0x5555 when latched col_en=1, else active_mask.
REQ-023 The FSM SHALL have two states, IDLE and RUN.
REQ-024 In IDLE, the block SHALL latch config, set row_ptr to the lowest set bit of the effective mask, and set word_cnt=0.
REQ-025 The FSM SHALL go from IDLE to RUN on the next edge if the effective mask is nonzero; otherwise it SHALL stay in IDLE.
REQ-026 in_ready SHALL be high exactly when state=RUN and fifo_full=0, combinationally.
REQ-027 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-028 On a transfer, the next cycle SHALL drive WR_EN=onehot(row_ptr) and din=in_data (latency 1, registered outputs).
REQ-029 On cycles with no transfer, WR_EN SHALL be 0 and din SHALL hold its last value.
REQ-030 word_cnt SHALL increment per transfer; when it reaches burst_len-1, word_cnt SHALL reset to 0 and row_ptr SHALL advance to the next higher set bit of the effective mask.
REQ-031 If no higher set bit exists in the effective mask, the frame SHALL end: frame_done SHALL pulse in the same cycle as that final WR_EN, and the FSM SHALL return to IDLE (one-cycle bubble, in_ready=0).
REQ-032 If fifo_full rises mid-burst, the block SHALL stall with word_cnt and row_ptr held, and SHALL resume with no word lost or duplicated.
REQ-033 A config write in the same cycle as the IDLE latch SHALL take effect in that latch (pending register updated first, same edge); a config write in RUN SHALL apply only at the next IDLE.
REQ-034 A single enabled row SHALL give a frame of exactly burst_len words.

Reset
REQ-035 On reset: pending and active mask=0xFFFF, burst_len=4, state=IDLE, row_ptr=0, word_cnt=0.
REQ-036 On reset: WR_EN=0, din=0, frame_done=0, busy=0, in_ready=0.
REQ-037 Reset asserted mid-frame SHALL abort immediately; the first post-reset frame SHALL start at row 0.

Verification
REQ-038 After reset, in_valid held high, fifo_full=0 -> WR_EN=0x0001 for 4 cycles, then 0x0002 ... up to 0x8000; frame_done with the 64th write; 1-cycle in_ready gap; repeat.
REQ-039 mask=0x0005, burst=2, col_en=0 -> WR_EN sequence 0x0001,0x0001,0x0004,0x0004; frame_done on the 4th write.
REQ-040 mask=0x000F, burst=1, col_en=1 -> writes go to rows 0 and 2 only; frame_done on the 2nd write.
REQ-041 fifo_full=1 for 3 cycles after the 2nd word of a burst -> in_ready=0 and WR_EN=0 for those cycles; the 3rd word lands on the same row afterwards.
REQ-042 Write mask=0x0000 or burst=0 -> ignored; write mask=0x0100 during RUN -> current frame finishes with the old mask, next frame uses row 8 only.
REQ-043 rst_n low in the middle of row 5 -> outputs clear asynchronously; after release, writes start at row 0 with word_cnt=0.

Source files
------------

// File: rtl/input_wr_dispatch.sv
// Host-to-input-FIFO write dispatcher: spreads incoming words over the enabled
// FIFO rows in bursts of burst_len words, one row at a time, and flags frame end.
module input_wr_dispatch #(
  parameter int unsigned DATA_IN_WIDTH  = 36,
  parameter int unsigned DATA_IN_ADDR   = 16,
  parameter int unsigned REG_ADDR       = 8,
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_IN_WIDTH-1:0]  in_data,
  output logic                      in_ready,
  input  logic                      reg_en,
  input  logic [REG_ADDR-1:0]       a_reg,
  input  logic [REG_DATA_WIDTH-1:0] d_reg,
  input  logic                      col_en,
  input  logic                      fifo_full,
  output logic [DATA_IN_ADDR-1:0]   WR_EN,
  output logic [DATA_IN_WIDTH-1:0]  din,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int unsigned ROWS  = DATA_IN_ADDR;
  localparam int unsigned PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [REG_ADDR-1:0] ADDR_MASK  = REG_ADDR'(1);
  localparam logic [REG_ADDR-1:0] ADDR_BURST = REG_ADDR'(2);

  function automatic logic [ROWS-1:0] even_rows();
    logic [ROWS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(ROWS); i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [ROWS-1:0] COL_MASK = even_rows();

  typedef enum logic {IDLE, RUN} state_e;

  state_e                   state_q, state_d;
  logic [ROWS-1:0]          pend_mask_q, pend_mask_d;
  logic [CNT_W-1:0]         pend_burst_q, pend_burst_d;
  logic [ROWS-1:0]          act_mask_q, act_mask_d;
  logic [CNT_W-1:0]         burst_q, burst_d;
  logic                     col_q, col_d;
  logic [PTR_W-1:0]         row_ptr_q, row_ptr_d;
  logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
  logic [ROWS-1:0]          wr_en_q, wr_en_d;
  logic [DATA_IN_WIDTH-1:0] din_q, din_d;
  logic                     frame_done_q, frame_done_d;

  logic [ROWS-1:0]  idle_eff, run_eff;
  logic [PTR_W-1:0] idle_low, nxt_row;
  logic             nxt_found;
  logic             xfer;
  logic             unused_d_reg;

  assign unused_d_reg = ^d_reg;

  assign in_ready   = (state_q == RUN) && !fifo_full;
  assign xfer       = in_valid && in_ready;
  assign busy       = (state_q == RUN);
  assign WR_EN      = wr_en_q;
  assign din        = din_q;
  assign frame_done = frame_done_q;

  // Pending config; zero writes are ignored so a mask/burst can never be empty.
  always_comb begin
    pend_mask_d  = pend_mask_q;
    pend_burst_d = pend_burst_q;
    if (reg_en && (a_reg == ADDR_MASK) && (d_reg[ROWS-1:0] != '0))
      pend_mask_d = d_reg[ROWS-1:0];
    if (reg_en && (a_reg == ADDR_BURST) && (d_reg[CNT_W-1:0] != '0))
      pend_burst_d = d_reg[CNT_W-1:0];
  end

  // IDLE looks through to this cycle's config write so it lands in the same latch.
  assign idle_eff = col_en ? (pend_mask_d & COL_MASK) : pend_mask_d;
  assign run_eff  = col_q  ? (act_mask_q & COL_MASK)  : act_mask_q;

  // Downward scan: last hit is the lowest qualifying row.
  always_comb begin
    idle_low  = '0;
    nxt_row   = '0;
    nxt_found = 1'b0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (idle_eff[i]) idle_low = PTR_W'(i);
      if (run_eff[i] && (PTR_W'(i) > row_ptr_q)) begin
        nxt_found = 1'b1;
        nxt_row   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    act_mask_d   = act_mask_q;
    burst_d      = burst_q;
    col_d        = col_q;
    row_ptr_d    = row_ptr_q;
    word_cnt_d   = word_cnt_q;
    wr_en_d      = '0;
    din_d        = din_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        act_mask_d = pend_mask_d;
        burst_d    = pend_burst_d;
        col_d      = col_en;
        row_ptr_d  = idle_low;
        word_cnt_d = '0;
        if (idle_eff != '0) state_d = RUN;
      end
      RUN: begin
        if (xfer) begin
          wr_en_d = ROWS'(1) << row_ptr_q;
          din_d   = in_data;
          if (word_cnt_q == burst_q - CNT_W'(1)) begin
            word_cnt_d = '0;
            if (nxt_found) begin
              row_ptr_d = nxt_row;
            end else begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_mask_q  <= '1;
      pend_burst_q <= CNT_W'(4);
      act_mask_q   <= '1;
      burst_q      <= CNT_W'(4);
      col_q        <= 1'b0;
      row_ptr_q    <= '0;
      word_cnt_q   <= '0;
      wr_en_q      <= '0;
      din_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_mask_q  <= pend_mask_d;
      pend_burst_q <= pend_burst_d;
      act_mask_q   <= act_mask_d;
      burst_q      <= burst_d;
      col_q        <= col_d;
      row_ptr_q    <= row_ptr_d;
      word_cnt_q   <= word_cnt_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
